// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, state encoding and clog2 helper for mux_scan_nxw
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    clog2 = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) clog2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/mux_nxw_comb.sv
// rtl/mux_nxw_comb.sv - combinational W-bit N:1 selector; select values >= N yield zero
module mux_nxw_comb
  import mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N*W-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) y = d[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_nxw.sv
// rtl/mux_scan_nxw.sv - N-channel W-bit manual/scan multiplexer with registered valid/ready output
// Optional channel skipping in scan mode: MUX_SCAN_SKIP_EN
module mux_scan_nxw
  import mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1,
  parameter int DWELL = 1,
  localparam int SEL_W = clog2(N)
) (
  input  logic clock,
  input  logic reset_b,
  input  logic [N*W-1:0] d,
  input  logic [SEL_W-1:0] sel,
  input  logic mode,
  input  logic enable,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N-1:0] ch_mask,
`endif
  output logic [W-1:0] y,
  output logic [SEL_W-1:0] y_ch,
  output logic y_valid,
  input  logic y_ready,
  output logic wrap
);

  localparam int DW_W = clog2(DWELL + 1);

  state_t state, next_state;
  logic [SEL_W-1:0] ptr, cur_ptr, tgt, nxt, first_en, mux_sel;
  logic [DW_W-1:0] cnt, cur_cnt;
  logic [N-1:0] mask;
  logic [W-1:0] mux_y;
  logic pend, pend_eff, scan_mode, entering, avail, load, advance, crossed;

`ifdef MUX_SCAN_SKIP_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  // Next enabled channel strictly after p, wrapping; p itself if it is the only one.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] p,
                                               input logic [N-1:0] m);
    int idx;
    next_en = p;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(p) + i) % N;
      if (m[SEL_W'(idx)]) next_en = SEL_W'(idx);
    end
  endfunction

  always_comb begin
    if (!enable) next_state = IDLE;
    else if (mode == MODE_SCAN) next_state = SCAN;
    else if (mode == MODE_MANUAL) next_state = MANUAL;
    else next_state = IDLE;

    first_en = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k]) first_en = SEL_W'(k);
    end

    scan_mode = (next_state == SCAN);
    entering  = scan_mode && (state != SCAN);
    cur_ptr   = entering ? first_en : ptr;
    cur_cnt   = entering ? '0 : cnt;
    pend_eff  = entering ? 1'b0 : pend;
    // A channel masked off since the last advance is hopped over at dwell start.
    tgt       = (!mask[cur_ptr] && cur_cnt == '0) ? next_en(cur_ptr, mask) : cur_ptr;
    nxt       = next_en(tgt, mask);
    crossed   = (nxt <= tgt);
    advance   = (cur_cnt == DW_W'(DWELL - 1));
    avail     = scan_mode ? (|mask) : 1'b1;
    load      = enable && (!y_valid || y_ready) && avail;
    mux_sel   = scan_mode ? tgt : sel;
  end

  mux_nxw_comb #(.N(N), .W(W)) u_sel (
    .d  (d),
    .sel(mux_sel),
    .y  (mux_y)
  );

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state <= next_state;
      if (entering) begin
        ptr  <= cur_ptr;
        cnt  <= '0;
        pend <= 1'b0;
      end
      if (load) begin
        y       <= mux_y;
        y_ch    <= mux_sel;
        y_valid <= 1'b1;
        wrap    <= scan_mode && pend_eff;
        if (scan_mode) begin
          if (advance) begin
            cnt  <= '0;
            ptr  <= nxt;
            pend <= crossed;
          end else begin
            cnt  <= cur_cnt + DW_W'(1);
            ptr  <= tgt;
            pend <= 1'b0;
          end
        end
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule
